// File: rtl/dummy_cp_app_copy_core.sv
// Streaming copy kernel: walks an EXTENT_X x EXTENT_Y domain, reads one pixel per
// cycle and re-emits it unchanged after a fixed DELAY-stage pipeline.
module dummy_cp_app_copy_core #(
  parameter int WIDTH    = 16,
  parameter int EXTENT_X = 64,
  parameter int EXTENT_Y = 64,
  parameter int DELAY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid,
  output logic [WIDTH-1:0] dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write [0:0],
  output logic             raw_oc_raw_update_0_read_en,
  input  logic [WIDTH-1:0] raw_oc_raw_update_0_read [0:0]
);

  localparam int XW = (EXTENT_X > 1) ? $clog2(EXTENT_X) : 1;
  localparam int YW = (EXTENT_Y > 1) ? $clog2(EXTENT_Y) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(EXTENT_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(EXTENT_Y - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [DELAY-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DELAY];
  logic             rd_en;
  logic             last_read;

  // The request is combinational so a flush or reset withdraws it within the cycle.
  assign rd_en     = (state_q == S_RUN) && !flush;
  assign last_read = rd_en && (x_q == X_LAST) && (y_q == Y_LAST);

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (flush) begin
      state_d = S_ARMED;
      x_d     = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ARMED: state_d = S_RUN;
        S_RUN: begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_read) state_d = S_DRAIN;
        end
        S_DRAIN: if (vld_q == '0) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the data pipeline is only DELAY words, so it is reset like any other
  // register; that is what makes the output read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DELAY; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's
      // old value, which is what makes this a shift rather than a wire.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vld_q[0] <= rd_en;
      for (int i = 1; i < DELAY; i++) vld_q[i] <= flush ? 1'b0 : vld_q[i-1];
      // Data stages only move with a valid beat so the output holds between pixels.
      if (!flush) begin
        if (rd_en) data_q[0] <= raw_oc_raw_update_0_read[0];
        for (int i = 1; i < DELAY; i++) begin
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign raw_oc_raw_update_0_read_en = rd_en;
  assign dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid = vld_q[DELAY-1];
  assign dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write[0]     = data_q[DELAY-1];

endmodule

// File: tb/tb_dummy_cp_app_copy_core.sv
// Bench for dummy_cp_app_copy_core: each sampled input is pushed to a scoreboard with
// its capture edge and popped against every valid output beat.
module tb_dummy_cp_app_copy_core;

  localparam int WIDTH = 16;
  localparam int EX    = 64;
  localparam int EY    = 64;
  localparam int DELAY = 2;
  localparam int N     = EX * EY;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               edge_n;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             wv;
  logic [WIDTH-1:0] wdata [0:0];
  logic             re_o;
  logic [WIDTH-1:0] rdata [0:0];
  logic [WIDTH-1:0] din;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  int   rd_cnt, wr_cnt, first_rd, last_rd, first_wr, last_wr;
  int   mode;

  always #5 clk = ~clk;
  assign rdata[0] = din;

  dummy_cp_app_copy_core #(
    .WIDTH(WIDTH), .EXTENT_X(EX), .EXTENT_Y(EY), .DELAY(DELAY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid(wv),
    .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write(wdata),
    .raw_oc_raw_update_0_read_en(re_o),
    .raw_oc_raw_update_0_read(rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Mode 0 counts up; mode 1 sends FFFF, then 0000, then random words.
  function automatic logic [WIDTH-1:0] next_din();
    if (mode == 0) return din + 1'b1;
    if (rd_cnt == 1) return '0;
    return WIDTH'($urandom);
  endfunction

  // One clock: capture the request before the edge, then score the output after it.
  task automatic cycle();
    logic re, fl;
    exp_t e;
    @(negedge clk);
    re = re_o;
    fl = flush;
    if (re) begin
      e.data   = din;
      e.edge_n = edge_n + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    edge_n++;
    #1;
    if (fl) begin
      check("read_en_during_flush", {31'd0, re}, 32'd0);
      sb.delete();
    end
    if (re) begin
      if (rd_cnt == 0) first_rd = edge_n;
      last_rd = edge_n;
      rd_cnt++;
      din = next_din();
    end
    if (wv) begin
      if (wr_cnt == 0) first_wr = edge_n;
      last_wr = edge_n;
      wr_cnt++;
      if (sb.size() == 0) begin
        check("spurious_write_valid", {31'd0, wv}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("write_data", {16'd0, wdata[0]}, {16'd0, e.data});
        check("write_latency", edge_n - e.edge_n, DELAY - 1);
      end
    end
  endtask

  task automatic start_run();
    rd_cnt = 0; wr_cnt = 0;
    first_rd = 0; last_rd = 0; first_wr = 0; last_wr = 0;
    sb.delete();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int budget;
    budget = N + 50;
    while (!(rd_cnt == N && sb.size() == 0) && budget > 0) begin
      cycle();
      budget--;
    end
    check({tag, "_timeout"}, {31'd0, budget > 0}, 32'd1);
    repeat (20) begin
      cycle();
      check({tag, "_done_read_en"}, {31'd0, re_o}, 32'd0);
    end
    check({tag, "_read_count"}, rd_cnt, N);
    check({tag, "_write_count"}, wr_cnt, N);
    check({tag, "_read_contig"}, last_rd - first_rd + 1, N);
    check({tag, "_write_contig"}, last_wr - first_wr + 1, N);
    check({tag, "_first_latency"}, first_wr - first_rd, DELAY - 1);
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    din   = '0;
    mode  = 0;

    // Reset held with the clock running: everything stays quiet.
    repeat (5) begin
      @(negedge clk);
      check("reset_read_en", {31'd0, re_o}, 32'd0);
      check("reset_write_valid", {31'd0, wv}, 32'd0);
      check("reset_write_data", {16'd0, wdata[0]}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Out of reset but never flushed: still idle.
    rd_cnt = 0; wr_cnt = 0;
    repeat (5) begin
      cycle();
      check("idle_read_en", {31'd0, re_o}, 32'd0);
    end

    // Full run with a counting input.
    mode = 0;
    din  = '0;
    start_run();
    run_to_done("run_count");

    // Extreme values first, then a flush at read index 100.
    mode = 1;
    din  = 16'hFFFF;
    start_run();
    for (int i = 0; i < 200 && rd_cnt < 100; i++) cycle();
    check("pre_flush_reads", rd_cnt, 100);
    check("pre_flush_writes", wr_cnt, 100 - DELAY + 1);
    start_run();
    run_to_done("run_reflush");

    // Asynchronous reset in the middle of a run.
    mode = 0;
    din  = 16'h1234;
    start_run();
    repeat (40) cycle();
    check("mid_run_read_en", {31'd0, re_o}, 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_read_en", {31'd0, re_o}, 32'd0);
    check("async_rst_write_valid", {31'd0, wv}, 32'd0);
    check("async_rst_write_data", {16'd0, wdata[0]}, 32'd0);
    sb.delete();
    repeat (5) begin
      cycle();
      check("rst_hold_read_en", {31'd0, re_o}, 32'd0);
    end
    rst_n = 1'b0;
    repeat (5) begin
      cycle();
      check("post_rst_idle_read_en", {31'd0, re_o}, 32'd0);
    end

    // Recovery after reset needs only a flush.
    din = '0;
    start_run();
    run_to_done("run_recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dummy_cp_app_copy_core.md
Name: dummy_cp_app_copy_core

Overview:
- Streaming copy kernel (Clockwork "dummy copy" app mapped to CGRA).
- Reads one 16-bit pixel per cycle from the raw input stream over an EXTENT_X x EXTENT_Y iteration domain.
- Re-emits each pixel unchanged, in order, on the output stream after a fixed pipeline delay.
- Sits between the host-side input stream driver and the output collector.

Parameters:
- WIDTH, 16, pixel data width.
- EXTENT_X, 64, inner loop extent (columns).
- EXTENT_Y, 64, outer loop extent (rows).
- DELAY, 2, clock edges from input sample to output presentation (must be ≥1).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-HIGH reset (despite the name; 1 = reset).
- flush  input  1  synchronous restart of the schedule.
- dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid  output  1  output pixel valid.
- dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write  output  1-element unpacked array [0:0] of WIDTH  output pixel.
- raw_oc_raw_update_0_read_en  output  1  input read request.
- raw_oc_raw_update_0_read  input  1-element unpacked array [0:0] of WIDTH  input pixel.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - controller to IDLE; counters x=y=0.
  - DELAY-stage data/valid pipeline cleared.
  - read_en=0, write_valid=0, write data=0.
  - Reset asserted mid-run aborts immediately; no further reads or writes until reset is released and flush is pulsed.
- flush (synchronous, higher priority than all non-reset state updates):
  - at any edge with flush=1: counters to 0, pipeline valids cleared, state to ARMED.
  - while flush=1, read_en=0.
- States:
  - IDLE → ARMED on flush.
  - ARMED → RUN at the first edge with flush=0.
  - RUN: read_en=1 every cycle, combinational from state.
  - RUN → DRAIN after the edge that samples read index EXTENT_X*EXTENT_Y-1.
  - DRAIN → DONE once the last pixel has left the pipeline.
  - DONE holds until the next flush.
  - A new flush from any state restarts the whole schedule.
- Input sampling:
  - In each RUN cycle, raw_oc_raw_update_0_read[0] is sampled at the rising edge ending that cycle.
  - The driver may change data only after that edge.
  - x increments per read; at x=EXTENT_X-1, x wraps to 0 and y increments.
- Output:
  - Pixel sampled at edge E is driven on write[0] with write_valid=1 during the cycle after edge E+DELAY-1.
  - One valid cycle per pixel; total exactly EXTENT_X*EXTENT_Y valid cycles per flush.
  - Order preserved; value bit-exact (no arithmetic).
  - write_valid=0 in all other cycles.
  - write data holds its last value when not valid; it is 0 after reset.
- Throughput: one pixel per cycle, no stalls. There is no backpressure input; consumers must accept every valid cycle.
- Boundary conditions:
  - The last read and the first DRAIN cycle are contiguous with no bubble.
  - With DELAY=1, the output register updates at the same edge as the sample.

Test Plan:
- Reset held (rst_n=1) with clock running → read_en=0 and write_valid=0 indefinitely; write[0]=0.
- Release reset, pulse flush for one cycle; driver increments input by 1 after each read_en cycle starting at 0 → exactly 4096 read_en cycles; outputs 0,1,…,4095 each with write_valid=1, first valid DELAY cycles after the first sample.
- Count cycles → read_en is contiguous 4096 cycles; write_valid is contiguous 4096 cycles; both are 0 afterwards (DONE).
- Input value 16'hFFFF then 16'h0000 → output 16'hFFFF, 16'h0000 (no sign or width alteration).
- Second flush asserted at read index 100 → pipeline valids cleared, no stale outputs; sequence restarts with x=y=0 and yields a full 4096 outputs.
- Assert rst_n asynchronously mid-RUN (between edges) → read_en and write_valid drop to 0 immediately, without waiting for a clock edge.
